cp0_exc_ctrl: RTL
=================

Name: cp0_exc_ctrl

Overview:
- Parametrised coprocessor-0 for the MIPS54 multicycle/pipelined core.
- Holds Status, Cause, EPC, Count, Compare and PRId.
- Prioritises synchronous exceptions (SYSCALL/BREAK/TEQ) and masked external interrupts, nests up to three exception levels through the Status shift stack, and supplies PC redirect addresses for exception entry and ERET.
- Sits beside the register file; driven by the decode/execute stage.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines, legal 1..7; IP[7] is reserved for the timer.
- EXC_VECTOR, 32'h00400004, exception entry address.
- PRID, 32'h00018000, constant returned for register 15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc  in  32  PC of the instruction in execute
- exc_req  in  1  execute instruction requests a synchronous exception
- exc_code  in  5  8 = SYSCALL, 9 = BREAK, 13 = TEQ; other codes are ignored
- teq_cond  in  1  TEQ comparison true (qualifies code 13)
- irq  in  NUM_IRQ  asynchronous level-sensitive interrupt lines
- int_ok  in  1  pipeline is at an instruction boundary where an interrupt may be taken
- mtc0  in  1  MTC0 write strobe
- eret  in  1  ERET in execute
- addr  in  5  CP0 register select
- wdata  in  32  MTC0 data
- rdata  out  32  MFC0 data (combinational on addr)
- exc_addr  out  32  redirect target
- exc_taken  out  1  flush/redirect strobe (combinational)
- int_pending  out  1  enabled interrupt pending
- status_o  out  32  Status register
- epc_o  out  32  EPC register

Behaviour:
- Reset: all registers 0; the synchroniser flops are cleared. Resulting outputs: rdata = 0 except PRId; exc_taken = 0; exc_addr = EXC_VECTOR.
- Status (reg 12) layout:
  - [0] IE global enable; [1] SYSCALL enable; [2] BREAK enable; [3] TEQ enable; [4] interrupt enable.
  - [14:5] holds two saved 5-bit frames.
  - [23:16] IM interrupt mask.
  - All other bits read 0.
- Cause (reg 13) is read-only:
  - [6:2] ExcCode (0 for interrupt).
  - [16+k] = synchronised irq[k].
  - [23] = timer pending.
- Interrupt input: irq passes through a 2-flop synchroniser, so an IP bit rises 2 clocks after irq rises.
- Sync exception condition: sync = IE & exc_req & one of:
  - code 8 & Status[1]
  - code 9 & Status[2]
  - code 13 & Status[3] & teq_cond
- Interrupt pending: int_pending = IE & Status[4] & |(Cause[23:16] & IM).
- Priority:
  - A sync exception beats an interrupt.
  - An interrupt requires int_ok and no exc_req.
  - exc_taken = sync | (int_pending & int_ok & ~exc_req).
- On exc_taken, at the next edge:
  - EPC <= pc.
  - Status[14:0] <= {Status[9:0], 5'b0}.
  - ExcCode <= code (or 0 for an interrupt).
  - exc_addr = EXC_VECTOR in the same cycle.
- On eret (and no exc_taken):
  - Status[14:0] <= {5'b0, Status[14:5]}.
  - exc_addr = EPC in the same cycle.
- Simultaneous events:
  - exc_taken beats eret and beats mtc0; the losing write is discarded.
  - mtc0 together with eret: the mtc0 is discarded.
- A third nested exception shifts the oldest frame out; it is lost and no error is flagged.
- MTC0 writes:
  - Status writes bits [23:16] and [14:0] only.
  - Writes to Cause, PRId and unimplemented registers are ignored.
- MFC0 reads:
  - Unimplemented registers read 0.
  - Reads are combinational, so a write is visible on the cycle after the edge.
- Reset mid-operation clears the nesting stack and any pending timer interrupt immediately.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined:
  - Count (reg 9) increments every clock and wraps 32'hFFFFFFFF -> 0.
  - mtc0 to Count loads wdata, which then increments from the following cycle.
  - Compare is reg 11.
  - Timer pending (Cause[23]) sets on the edge after Count == Compare with Compare != 0, and stays set until mtc0 writes Compare.
  - Count/Compare hold at reset: 0.
- When undefined: regs 9 and 11 read 0, writes to them are ignored, and Cause[23] = 0.

Test Plan:
- SYSCALL taken: set Status = 32'h3, pulse exc_req with code 8 at pc = 32'h00400020.
  - Same cycle: exc_taken = 1, exc_addr = 32'h00400004.
  - Next cycle: EPC = 32'h00400020, Status = 32'h60, Cause = 32'h20.
- ERET restore: after the SYSCALL case, assert eret.
  - Same cycle: exc_addr = 32'h00400020.
  - Next cycle: Status = 32'h3.
- TEQ gating: set Status = 32'h9, code 13.
  - teq_cond = 0: exc_taken = 0.
  - teq_cond = 1: taken with Cause = 32'h34.
- Interrupt with mask: set Status = 32'h00010011, raise irq[0].
  - int_pending goes high 2 cycles after irq[0] rises.
  - With int_ok = 1: exc_taken = 1 and ExcCode = 0.
  - With IM = 0: no interrupt is taken.
- Collision: assert exc_req (code 9, Status = 32'h5) with mtc0 to EPC at the same time.
  - EPC = pc, and wdata is discarded.
  - Also: mtc0 Status together with eret leaves Status as the shifted value.
- Timer (CP0_TIMER_EN): set Compare = 10, Status = 32'h00800011.
  - After reset, int_pending rises on cycle 11.
  - A Compare write clears it.
  - Count preload 32'hFFFFFFFE wraps to 0 two cycles later.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 for the MIPS54 core.
// Holds Status, Cause, EPC, PRId and, when built with CP0_TIMER_EN defined, the
// Count/Compare timer.
// Prioritises synchronous exceptions over masked interrupts. Nests up to three
// exception levels through the Status frame stack. Supplies the PC redirect
// target for exception entry and ERET.
module cp0_exc_ctrl #(
    parameter int unsigned NUM_IRQ    = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004,
    parameter logic [31:0] PRID       = 32'h00018000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic               teq_cond,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               int_ok,
    input  logic               mtc0,
    input  logic               eret,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [31:0]        exc_addr,
    output logic               exc_taken,
    output logic               int_pending,
    output logic [31:0]        status_o,
    output logic [31:0]        epc_o
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [4:0] CODE_SYSCALL = 5'd8;
    localparam logic [4:0] CODE_BREAK   = 5'd9;
    localparam logic [4:0] CODE_TEQ     = 5'd13;

    // Architectural state: frame stack Status[14:0], mask Status[23:16], Cause ExcCode, EPC
    logic [14:0]        stk_q, stk_d;
    logic [7:0]         im_q, im_d;
    logic [4:0]         excode_q, excode_d;
    logic [31:0]        epc_q, epc_d;
    logic [NUM_IRQ-1:0] irq_meta_q, irq_sync_q;

    logic        timer_pend;
    logic [31:0] count_val, compare_val;
    logic [7:0]  ip;
    logic        sync_exc;
    logic        wr_en;
    logic [31:0] cause_val;

    // Only Status[23:16] and [14:0] are writable; the other data bits have no home.
    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:24], wdata[15]};

    // Pending-interrupt vector: synchronised lines plus the timer in IP[7]
    always_comb begin
        ip              = '0;
        ip[NUM_IRQ-1:0] = irq_sync_q;
        ip[7]           = timer_pend;
    end

    assign cause_val   = {8'b0, ip, 9'b0, excode_q, 2'b0};
    assign status_o    = {8'b0, im_q, 1'b0, stk_q};
    assign epc_o       = epc_q;

    assign sync_exc    = stk_q[0] & exc_req &
                         (((exc_code == CODE_SYSCALL) & stk_q[1]) |
                          ((exc_code == CODE_BREAK)   & stk_q[2]) |
                          ((exc_code == CODE_TEQ)     & stk_q[3] & teq_cond));
    assign int_pending = stk_q[0] & stk_q[4] & (|(ip & im_q));
    assign exc_taken   = sync_exc | (int_pending & int_ok & ~exc_req);
    assign exc_addr    = (eret && !exc_taken) ? epc_q : EXC_VECTOR;

    // An MTC0 loses to a simultaneous exception entry or ERET
    assign wr_en       = mtc0 & ~exc_taken & ~eret;

    // Next-state for Status, Cause and EPC: exception entry > ERET > MTC0
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        stk_d    = stk_q;
        im_d     = im_q;
        excode_d = excode_q;
        epc_d    = epc_q;
        if (exc_taken) begin
            stk_d    = {stk_q[9:0], 5'b0};
            excode_d = sync_exc ? exc_code : 5'd0;
            epc_d    = pc;
        end else if (eret) begin
            stk_d = {5'b0, stk_q[14:5]};
        end else if (wr_en) begin
            if (addr == REG_STATUS) begin
                stk_d = wdata[14:0];
                im_d  = wdata[23:16];
            end
            if (addr == REG_EPC) epc_d = wdata;
        end
    end

    // State registers and the two-flop interrupt synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_q      <= '0;
            im_q       <= '0;
            excode_q   <= '0;
            epc_q      <= '0;
            irq_meta_q <= '0;
            irq_sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            stk_q      <= stk_d;
            im_q       <= im_d;
            excode_q   <= excode_d;
            epc_q      <= epc_d;
            irq_meta_q <= irq;
            irq_sync_q <= irq_meta_q;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        tpend_q, tpend_d;

    // Timer next-state: free-running count, match sets pending, Compare write clears it
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        tpend_d   = tpend_q;
        if ((count_q == compare_q) && (compare_q != 32'd0)) tpend_d = 1'b1;
        if (wr_en && (addr == REG_COUNT)) count_d = wdata;
        if (wr_en && (addr == REG_COMPARE)) begin
            compare_d = wdata;
            tpend_d   = 1'b0;
        end
    end

    // Timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            tpend_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tpend_q   <= tpend_d;
        end
    end

    assign timer_pend  = tpend_q;
    assign count_val   = count_q;
    assign compare_val = compare_q;
`else
    assign timer_pend  = 1'b0;
    assign count_val   = 32'd0;
    assign compare_val = 32'd0;
`endif

    // MFC0 read mux; unimplemented registers read 0
    always_comb begin
        rdata = 32'd0;
        case (addr)
            REG_COUNT:   rdata = count_val;
            REG_COMPARE: rdata = compare_val;
            REG_STATUS:  rdata = status_o;
            REG_CAUSE:   rdata = cause_val;
            REG_EPC:     rdata = epc_q;
            REG_PRID:    rdata = PRID;
            default:     rdata = 32'd0;
        endcase
    end

endmodule
